// File: rtl/note_seq_pkg.sv
// Shared encodings for the note record/playback sequencer.
package note_seq_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_RECORD = 2'd1,
        MODE_PLAY   = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        NOTE_REST = 3'd0,
        NOTE_DO   = 3'd1,
        NOTE_RE   = 3'd2,
        NOTE_MI   = 3'd3,
        NOTE_FA   = 3'd4,
        NOTE_SOL  = 3'd5,
        NOTE_LA   = 3'd6,
        NOTE_SI   = 3'd7
    } note_t;

    localparam int NOTE_W = 3;

    // Entry layout is {note[NOTE_W-1:0], dur[dur_w-1:0]}, note in the MSBs.
    function automatic int entry_w(input int dur_w);
        return NOTE_W + dur_w;
    endfunction

endpackage

// File: rtl/note_event_buffer.sv
// Event register file: one synchronous write port, one combinational read port.
module note_event_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 11,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// Record/playback controller between keyboard front end and note decoder.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int DUR_W = 8,
    parameter int LOOP  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [2:0]               live_note,
    input  logic                     btn_record,
    input  logic                     btn_play,
    output logic [2:0]               note_out,
    output logic [1:0]               mode,
    output logic [$clog2(DEPTH):0]   rec_len,
    output logic                     rec_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [DUR_W-1:0] MAX_DUR = '1;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } entry_t;

    mode_t            state_q, state_d;
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
    logic [2:0]       cur_note;
    logic [DUR_W-1:0] dur_cnt, remain, dsum;
    entry_t           wr_entry, rd_entry;
    logic             we, changed, full_hit, adv, last, enter_rec, enter_play;

    note_event_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (entry_w(DUR_W)),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .we      (we),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_nxt),
        .rd_data (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= MODE_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MODE_IDLE:   if (btn_record) state_d = MODE_RECORD;
                         else if (enter_play) state_d = MODE_PLAY;
            MODE_RECORD: if (full_hit || btn_record) state_d = MODE_IDLE;
            MODE_PLAY:   if (btn_play || (adv && last && LOOP == 0)) state_d = MODE_IDLE;
            default:     state_d = MODE_IDLE;
        endcase
    end

    // Every RECORD write (change, saturation, flush) stores {cur_note, dur_cnt+tick},
    // so one write condition covers all cases and a zero duration never lands.
    always_comb begin
        mode       = state_q;
        changed    = live_note != cur_note;
        dsum       = dur_cnt + DUR_W'(tick);
        we         = (state_q == MODE_RECORD) && (dsum != '0) &&
                     (changed || dsum == MAX_DUR || btn_record);
        full_hit   = we && (wr_ptr == AW'(DEPTH - 1));
        wr_entry   = '{note: cur_note, dur: dsum};
        adv        = (state_q == MODE_PLAY) && tick && (remain == DUR_W'(1));
        last       = (LW'(rd_ptr) + LW'(1)) == rec_len;
        enter_rec  = (state_q == MODE_IDLE) && btn_record;
        enter_play = (state_q == MODE_IDLE) && !btn_record && btn_play && (rec_len != '0);
        // Read address is the pointer's next value so a load sees its entry the same edge.
        rd_nxt = rd_ptr;
        if (state_q != MODE_PLAY || (adv && last)) rd_nxt = '0;
        else if (adv)                              rd_nxt = rd_ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            note_out <= '0;
            rec_len  <= '0;
            rec_full <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            dur_cnt  <= '0;
            remain   <= '0;
            cur_note <= '0;
        end else begin
            rd_ptr   <= rd_nxt;
            note_out <= (state_d == MODE_PLAY) ? rd_entry.note : live_note;

            if (enter_play || (adv && state_d == MODE_PLAY))
                remain <= rd_entry.dur;
            else if (state_q == MODE_PLAY && tick && remain > DUR_W'(1))
                remain <= remain - 1'b1;

            if (enter_rec) begin
                wr_ptr   <= '0;
                rec_full <= 1'b0;
                rec_len  <= '0;
                cur_note <= live_note;
                dur_cnt  <= '0;
            end else if (state_q == MODE_RECORD) begin
                cur_note <= live_note;
                if (we || changed) dur_cnt <= '0;
                else if (tick)     dur_cnt <= dur_cnt + 1'b1;
                if (we) wr_ptr <= wr_ptr + 1'b1;
                if (full_hit) begin
                    rec_full <= 1'b1;
                    rec_len  <= LW'(DEPTH);
                end else if (btn_record) begin
                    rec_len  <= LW'(wr_ptr) + LW'(we);
                end
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a cycle table plus multi-cycle corner sequences.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       rst, tick, btn_record, btn_play;
    logic [2:0] live_note;

    logic [2:0] note_out, note4;
    logic [1:0] mode, mode4;
    logic [5:0] rec_len;
    logic [2:0] len4;
    logic       rec_full, full4;

    int n_err = 0;
    int n_chk = 0;

    note_sequencer #(.DEPTH(32), .DUR_W(8), .LOOP(0)) dut (
        .clk(clk), .rst(rst), .tick(tick), .live_note(live_note),
        .btn_record(btn_record), .btn_play(btn_play),
        .note_out(note_out), .mode(mode), .rec_len(rec_len), .rec_full(rec_full)
    );

    note_sequencer #(.DEPTH(4), .DUR_W(8), .LOOP(1)) dut4 (
        .clk(clk), .rst(rst), .tick(tick), .live_note(live_note),
        .btn_record(btn_record), .btn_play(btn_play),
        .note_out(note4), .mode(mode4), .rec_len(len4), .rec_full(full4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rst, tick, live, brec, bplay;
        int note, mode, len, full;
    } vec_t;

    vec_t tbl [30];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; tick = 1'b0; btn_record = 1'b0; btn_play = 1'b0; live_note = 3'd0;
        step;
        rst = 1'b0;
    endtask

    task automatic tick1;
        tick = 1'b1;
        step;
        tick = 1'b0;
    endtask

    task automatic press_rec;
        btn_record = 1'b1;
        step;
        btn_record = 1'b0;
    endtask

    task automatic press_play;
        btn_play = 1'b1;
        step;
        btn_play = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; btn_record = 1'b0; btn_play = 1'b0; live_note = 3'd0;

        //        rst tk lv rec ply | note mode len full
        tbl = '{
            '{1, 0, 0, 0, 0,  0, 0, 0, 0},
            '{0, 0, 3, 0, 0,  3, 0, 0, 0},
            '{0, 0, 3, 0, 1,  3, 0, 0, 0},
            '{0, 0, 1, 1, 0,  1, 1, 0, 0},
            '{0, 1, 1, 0, 0,  1, 1, 0, 0},
            '{0, 1, 1, 0, 0,  1, 1, 0, 0},
            '{0, 1, 1, 0, 0,  1, 1, 0, 0},
            '{0, 1, 1, 0, 0,  1, 1, 0, 0},
            '{0, 0, 0, 0, 0,  0, 1, 0, 0},
            '{0, 1, 0, 0, 0,  0, 1, 0, 0},
            '{0, 1, 0, 0, 0,  0, 1, 0, 0},
            '{0, 0, 5, 0, 0,  5, 1, 0, 0},
            '{0, 1, 5, 0, 0,  5, 1, 0, 0},
            '{0, 1, 5, 0, 0,  5, 1, 0, 0},
            '{0, 1, 5, 0, 1,  5, 1, 0, 0},
            '{0, 0, 5, 1, 0,  5, 0, 3, 0},
            '{0, 0, 0, 0, 1,  1, 2, 3, 0},
            '{0, 1, 0, 0, 0,  1, 2, 3, 0},
            '{0, 1, 0, 0, 0,  1, 2, 3, 0},
            '{0, 1, 0, 0, 0,  1, 2, 3, 0},
            '{0, 1, 0, 0, 0,  0, 2, 3, 0},
            '{0, 1, 0, 0, 0,  0, 2, 3, 0},
            '{0, 1, 0, 0, 0,  5, 2, 3, 0},
            '{0, 0, 0, 0, 0,  5, 2, 3, 0},
            '{0, 1, 0, 0, 0,  5, 2, 3, 0},
            '{0, 1, 0, 0, 0,  5, 2, 3, 0},
            '{0, 1, 0, 0, 0,  0, 0, 3, 0},
            '{0, 0, 6, 0, 0,  6, 0, 3, 0},
            '{0, 0, 6, 1, 1,  6, 1, 0, 0},
            '{1, 0, 6, 0, 0,  0, 0, 0, 0}
        };

        for (int i = 0; i < 30; i++) begin
            rst        = (tbl[i].rst != 0);
            tick       = (tbl[i].tick != 0);
            live_note  = 3'(tbl[i].live);
            btn_record = (tbl[i].brec != 0);
            btn_play   = (tbl[i].bplay != 0);
            step;
            chk($sformatf("vec%0d.note", i), int'(note_out), tbl[i].note);
            chk($sformatf("vec%0d.mode", i), int'(mode),     tbl[i].mode);
            chk($sformatf("vec%0d.len",  i), int'(rec_len),  tbl[i].len);
            chk($sformatf("vec%0d.full", i), int'(rec_full), tbl[i].full);
        end

        // Glitch discarded, then a change coinciding with a tick at dur_cnt=2.
        do_reset;
        live_note = 3'd1; press_rec;
        live_note = 3'd2; step;
        tick1; tick1;
        live_note = 3'd3; tick1;
        tick1;
        press_rec;
        chk("glitch.len", int'(rec_len), 2);
        chk("glitch.mode", int'(mode), 0);
        live_note = 3'd0;
        press_play;
        chk("glitch.play0", int'(note_out), 2);
        tick1; tick1;
        chk("glitch.play2", int'(note_out), 2);
        tick1;
        chk("glitch.play3", int'(note_out), 3);
        tick1;
        chk("glitch.end", int'(mode), 0);

        // btn_play mid-playback stops at once; a new play restarts at entry 0.
        press_play;
        tick1;
        press_play;
        chk("stop.mode", int'(mode), 0);
        chk("stop.len", int'(rec_len), 2);
        press_play;
        chk("restart.mode", int'(mode), 2);
        chk("restart.note", int'(note_out), 2);
        press_play;

        // Saturation: 300 ticks of one note split into 255 + 45.
        do_reset;
        live_note = 3'd2; press_rec;
        repeat (300) tick1;
        press_rec;
        chk("sat.len", int'(rec_len), 2);
        chk("sat.full", int'(rec_full), 0);
        press_play;
        repeat (299) tick1;
        chk("sat.mode299", int'(mode), 2);
        chk("sat.note299", int'(note_out), 2);
        tick1;
        chk("sat.mode300", int'(mode), 0);

        // Full buffer on the DEPTH=4 instance: five 1-tick notes.
        do_reset;
        live_note = 3'd1; press_rec;
        for (int k = 1; k <= 5; k++) begin
            tick = 1'b1;
            live_note = 3'(k + 1);
            step;
            if (k == 4) begin
                chk("full.mode", int'(mode4), 0);
                chk("full.flag", int'(full4), 1);
                chk("full.len", int'(len4), 4);
            end
        end
        tick = 1'b0;
        chk("full.len_after", int'(len4), 4);

        // LOOP=1 playback wraps after entry 3 back to entry 0.
        live_note = 3'd0;
        press_play;
        chk("loop.e0", int'(note4), 1);
        tick1; chk("loop.e1", int'(note4), 2);
        tick1; chk("loop.e2", int'(note4), 3);
        tick1; chk("loop.e3", int'(note4), 4);
        tick1;
        chk("loop.wrap_note", int'(note4), 1);
        chk("loop.wrap_mode", int'(mode4), 2);
        press_rec;
        chk("loop.rec_ignored", int'(mode4), 2);
        press_play;
        chk("loop.stop", int'(mode4), 0);

        // Reset in the middle of a recording.
        do_reset;
        live_note = 3'd4; press_rec;
        tick1; tick1; tick1;
        rst = 1'b1; step; rst = 1'b0;
        chk("rst.note", int'(note_out), 0);
        chk("rst.mode", int'(mode), 0);
        chk("rst.len", int'(rec_len), 0);
        chk("rst.full", int'(rec_full), 0);
        press_play;
        chk("rst.play_ignored", int'(mode), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
